// File: rtl/parking_pkg.sv
// Shared definitions for the car-park gate sequencer and display controller:
// FSM encoding, BCD digit geometry and display word packing helpers.
package parking_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ENTRY_OPEN = 2'd1;
    localparam logic [1:0] ST_EXIT_OPEN  = 2'd2;
    localparam logic [1:0] ST_RELEASE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE       = ST_IDLE,
        S_ENTRY_OPEN = ST_ENTRY_OPEN,
        S_EXIT_OPEN  = ST_EXIT_OPEN,
        S_RELEASE    = ST_RELEASE
    } state_e;

    localparam int DIGIT_W = 4;

    localparam int OCC_TENS_LSB   = 12;
    localparam int OCC_UNITS_LSB  = 8;
    localparam int FREE_TENS_LSB  = 4;
    localparam int FREE_UNITS_LSB = 0;

    // Binary 0..99 to two packed BCD digits.
    function automatic logic [2*DIGIT_W-1:0] to_bcd2(input logic [7:0] v);
        return {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

    function automatic logic [15:0] pack_bcd(input logic [7:0] occ, input logic [7:0] fr);
        logic [15:0] w;
        w = '0;
        w[OCC_TENS_LSB   +: DIGIT_W] = occ[7:4];
        w[OCC_UNITS_LSB  +: DIGIT_W] = occ[3:0];
        w[FREE_TENS_LSB  +: DIGIT_W] = fr[7:4];
        w[FREE_UNITS_LSB +: DIGIT_W] = fr[3:0];
        return w;
    endfunction

endpackage

// File: rtl/bcd2_incdec.sv
// Two-digit BCD increment/decrement, saturating at 00 and at max_i.
module bcd2_incdec
    import parking_pkg::*;
(
    input  logic [2*DIGIT_W-1:0] val_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    input  logic [2*DIGIT_W-1:0] max_i,
    output logic [2*DIGIT_W-1:0] val_o
);

    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;

    assign tens  = val_i[2*DIGIT_W-1:DIGIT_W];
    assign units = val_i[DIGIT_W-1:0];

    // Packed BCD keeps numeric ordering, so a plain compare gives the bound.
    always_comb begin
        val_o = val_i;
        if (inc_i && !dec_i && (val_i < max_i)) begin
            if (units == 4'd9) val_o = {tens + 4'd1, 4'd0};
            else               val_o = {tens, units + 4'd1};
        end else if (dec_i && !inc_i && (val_i != '0)) begin
            if (units == 4'd0) val_o = {tens - 4'd1, 4'd9};
            else               val_o = {tens, units - 4'd1};
        end
    end

endmodule

// File: rtl/parking_display_ctrl.sv
// Entry/exit gate sequencer owning the occupied/free counts, plus the display
// scan tick and full-park flash control.
module parking_display_ctrl
    import parking_pkg::*;
#(
    parameter logic [7:0]  CAPACITY    = 8'd20,
    parameter logic [15:0] GATE_CYCLES = 16'd50000,
    parameter logic [15:0] SCAN_DIV    = 16'd1000,
    parameter logic [23:0] FLASH_DIV   = 24'd500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        entry_req,
    input  logic        exit_req,
    input  logic        entry_done,
    input  logic        exit_done,
    output logic        gate_in_open,
    output logic        gate_out_open,
    output logic        entry_ack,
    output logic        exit_ack,
    output logic        entry_deny,
    output logic        full,
    output logic [15:0] bcd_out,
    output logic        scan_tick,
    output logic        blank
);

    localparam logic [7:0]  CAP_BCD    = to_bcd2(CAPACITY);
    localparam logic [15:0] GATE_LAST  = GATE_CYCLES - 16'd1;
    localparam logic [15:0] SCAN_LAST  = SCAN_DIV - 16'd1;
    localparam logic [23:0] FLASH_LAST = FLASH_DIV - 24'd1;

    state_e      state_q;
    logic        served_exit_q;
    logic [15:0] timer_q;
    logic        gate_in_q, gate_out_q;
    logic        entry_ack_q, exit_ack_q, entry_deny_q;
    logic [7:0]  occ_q, free_q, occ_d, free_d;
    logic        full_q;
    logic [15:0] bcd_q;
    logic [15:0] scan_q;
    logic        scan_tick_q;
    logic [23:0] flash_q;
    logic        blank_q;

    logic count_in, count_out, exit_grant, timer_last;

    assign count_in   = (state_q == S_ENTRY_OPEN) && entry_done;
    assign count_out  = (state_q == S_EXIT_OPEN) && exit_done;
    assign exit_grant = exit_req && (occ_q != 8'h00);
    assign timer_last = (timer_q == GATE_LAST);

    bcd2_incdec u_occ (
        .val_i (occ_q),
        .inc_i (count_in),
        .dec_i (count_out),
        .max_i (CAP_BCD),
        .val_o (occ_d)
    );

    bcd2_incdec u_free (
        .val_i (free_q),
        .inc_i (count_out),
        .dec_i (count_in),
        .max_i (CAP_BCD),
        .val_o (free_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            served_exit_q <= 1'b0;
            timer_q       <= '0;
            gate_in_q     <= 1'b0;
            gate_out_q    <= 1'b0;
            entry_ack_q   <= 1'b0;
            exit_ack_q    <= 1'b0;
            entry_deny_q  <= 1'b0;
            occ_q         <= 8'h00;
            free_q        <= CAP_BCD;
            full_q        <= 1'b0;
            bcd_q         <= pack_bcd(8'h00, CAP_BCD);
        end else begin
            entry_ack_q  <= 1'b0;
            exit_ack_q   <= 1'b0;
            entry_deny_q <= 1'b0;
            occ_q        <= occ_d;
            free_q       <= free_d;
            full_q       <= (occ_d == CAP_BCD);
            bcd_q        <= pack_bcd(occ_q, free_q);
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (exit_grant) begin
                        state_q    <= S_EXIT_OPEN;
                        gate_out_q <= 1'b1;
                    end else if (entry_req && !full_q) begin
                        state_q   <= S_ENTRY_OPEN;
                        gate_in_q <= 1'b1;
                    end else if (entry_req) begin
                        entry_deny_q <= 1'b1;
                    end
                end
                S_ENTRY_OPEN: begin
                    if (entry_done || timer_last) begin
                        state_q       <= S_RELEASE;
                        gate_in_q     <= 1'b0;
                        served_exit_q <= 1'b0;
                        entry_ack_q   <= entry_done;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_EXIT_OPEN: begin
                    if (exit_done || timer_last) begin
                        state_q       <= S_RELEASE;
                        gate_out_q    <= 1'b0;
                        served_exit_q <= 1'b1;
                        exit_ack_q    <= exit_done;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_RELEASE: begin
                    // One car holds its request line; wait for it to drop.
                    if (served_exit_q ? !exit_req : !entry_req)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q      <= '0;
            scan_tick_q <= 1'b0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q      <= '0;
            scan_tick_q <= 1'b1;
        end else begin
            scan_q      <= scan_q + 16'd1;
            scan_tick_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_q <= '0;
            blank_q <= 1'b0;
        end else if (!full_q) begin
            flash_q <= '0;
            blank_q <= 1'b0;
        end else if (flash_q == FLASH_LAST) begin
            flash_q <= '0;
            blank_q <= ~blank_q;
        end else begin
            flash_q <= flash_q + 24'd1;
        end
    end

    assign gate_in_open  = gate_in_q;
    assign gate_out_open = gate_out_q;
    assign entry_ack     = entry_ack_q;
    assign exit_ack      = exit_ack_q;
    assign entry_deny    = entry_deny_q;
    assign full          = full_q;
    assign bcd_out       = bcd_q;
    assign scan_tick     = scan_tick_q;
    assign blank         = blank_q;

endmodule

// File: tb/tb_parking_display_ctrl.sv
// Scoreboard bench for parking_display_ctrl with a 3-space park and short timers.
module tb_parking_display_ctrl;

    localparam int CAP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        entry_req, exit_req, entry_done, exit_done;
    logic        gate_in_open, gate_out_open, entry_ack, exit_ack;
    logic        entry_deny, full, scan_tick, blank;
    logic [15:0] bcd_out;

    parking_display_ctrl #(
        .CAPACITY    (8'd3),
        .GATE_CYCLES (16'd8),
        .SCAN_DIV    (16'd4),
        .FLASH_DIV   (24'd6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .entry_done    (entry_done),
        .exit_done     (exit_done),
        .gate_in_open  (gate_in_open),
        .gate_out_open (gate_out_open),
        .entry_ack     (entry_ack),
        .exit_ack      (exit_ack),
        .entry_deny    (entry_deny),
        .full          (full),
        .bcd_out       (bcd_out),
        .scan_tick     (scan_tick),
        .blank         (blank)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int occ_m = 0;
    int ack_seen = 0;

    typedef struct {
        bit          is_exit;
        logic [15:0] bcd;
    } exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_bcd(input int occ);
        int fr;
        fr = CAP - occ;
        return {4'(occ / 10), 4'(occ % 10), 4'(fr / 10), 4'(fr % 10)};
    endfunction

    function automatic bit sig(input int w);
        case (w)
            0:       return gate_in_open;
            1:       return gate_out_open;
            2:       return scan_tick;
            default: return gate_in_open | gate_out_open;
        endcase
    endfunction

    task automatic wait_hi(input int which, input int limit, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sig(which)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val(tag, 0, 1);
    endtask

    // Ack monitor: the count shows on bcd_out the cycle after the ack pulse.
    bit cmp_next = 1'b0;
    bit last_exit = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            cmp_next = 1'b0;
        end else begin
            if (cmp_next) begin
                cmp_next = 1'b0;
                if (sb.size() == 0) begin
                    check_val("ack_without_stimulus", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("ack_kind", 32'(last_exit), 32'(e.is_exit));
                    check_val("bcd_after_ack", 32'(bcd_out), 32'(e.bcd));
                    $display("txn %s ack bcd_out=%04h expected=%04h",
                             e.is_exit ? "exit" : "entry", bcd_out, e.bcd);
                end
            end
            if (entry_ack || exit_ack) begin
                cmp_next  = 1'b1;
                last_exit = exit_ack;
                ack_seen++;
            end
        end
    end

    task automatic do_entry(input int delay);
        @(posedge clk); #1 entry_req = 1'b1;
        wait_hi(0, 12, "entry_gate_open_timeout");
        repeat (delay) @(posedge clk);
        #1 entry_done = 1'b1;
        occ_m++;
        sb.push_back('{1'b0, model_bcd(occ_m)});
        @(posedge clk); #1 entry_done = 1'b0; entry_req = 1'b0;
        repeat (3) @(negedge clk);
        check_val("entry_gate_closed", 32'(gate_in_open), 0);
        check_val("entry_bcd_idle", 32'(bcd_out), 32'(model_bcd(occ_m)));
    endtask

    task automatic do_exit(input int delay);
        @(posedge clk); #1 exit_req = 1'b1;
        wait_hi(1, 12, "exit_gate_open_timeout");
        repeat (delay) @(posedge clk);
        #1 exit_done = 1'b1;
        occ_m--;
        sb.push_back('{1'b1, model_bcd(occ_m)});
        @(posedge clk); #1 exit_done = 1'b0; exit_req = 1'b0;
        repeat (3) @(negedge clk);
        check_val("exit_gate_closed", 32'(gate_out_open), 0);
        check_val("exit_bcd_idle", 32'(bcd_out), 32'(model_bcd(occ_m)));
    endtask

    initial begin
        int n;
        int acks_before;
        int reopen;
        bit b;

        reset = 1'b1;
        entry_req = 1'b0; exit_req = 1'b0; entry_done = 1'b0; exit_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_bcd", 32'(bcd_out), 32'h0003);
        check_val("rst_gates", 32'({gate_in_open, gate_out_open}), 0);
        check_val("rst_flags", 32'({entry_ack, exit_ack, entry_deny, full, blank, scan_tick}), 0);
        reset = 1'b0;

        // Scan tick period.
        wait_hi(2, 10, "scan_first_timeout");
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (scan_tick) break;
        end
        check_val("scan_period", n, 4);

        // Fill the park.
        do_entry(3);
        check_val("bcd_one_car", 32'(bcd_out), 32'h0102);
        do_entry(1);
        do_entry(2);
        check_val("full_set", 32'(full), 1);

        // Held entry request while full is refused.
        @(posedge clk); #1 entry_req = 1'b1;
        repeat (3) @(negedge clk);
        check_val("deny_when_full", 32'(entry_deny), 1);
        check_val("no_gate_when_full", 32'(gate_in_open), 0);

        // Flash half-period.
        b = blank;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (blank != b) break;
        end
        b = blank;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (blank != b) break;
        end
        check_val("blank_half_period", n, 6);
        @(posedge clk); #1 entry_req = 1'b0;
        repeat (2) @(negedge clk);
        check_val("deny_released", 32'(entry_deny), 0);

        // One exit clears full and the flash.
        do_exit(2);
        check_val("full_cleared", 32'(full), 0);
        check_val("blank_cleared", 32'(blank), 0);

        // Simultaneous requests: exit wins, entry served afterwards.
        @(posedge clk); #1 entry_req = 1'b1; exit_req = 1'b1;
        wait_hi(3, 12, "prio_gate_timeout");
        check_val("prio_exit_open", 32'(gate_out_open), 1);
        check_val("prio_entry_closed", 32'(gate_in_open), 0);
        repeat (2) @(posedge clk);
        #1 exit_done = 1'b1;
        occ_m--;
        sb.push_back('{1'b1, model_bcd(occ_m)});
        @(posedge clk); #1 exit_done = 1'b0; exit_req = 1'b0;
        wait_hi(0, 12, "entry_after_exit_timeout");
        repeat (1) @(posedge clk);
        #1 entry_done = 1'b1;
        occ_m++;
        sb.push_back('{1'b0, model_bcd(occ_m)});
        @(posedge clk); #1 entry_done = 1'b0; entry_req = 1'b0;
        repeat (3) @(negedge clk);
        check_val("bcd_after_prio", 32'(bcd_out), 32'(model_bcd(occ_m)));

        // Entry gate timeout, no reopen while the request is held.
        acks_before = ack_seen;
        @(posedge clk); #1 entry_req = 1'b1;
        wait_hi(0, 12, "timeout_gate_open_timeout");
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (gate_in_open) n++;
            else break;
        end
        check_val("timeout_open_cycles", n, 8);
        reopen = 0;
        repeat (6) begin
            @(negedge clk);
            if (gate_in_open) reopen++;
        end
        check_val("no_reopen_while_held", reopen, 0);
        check_val("timeout_no_ack", ack_seen, acks_before);
        check_val("timeout_bcd_kept", 32'(bcd_out), 32'(model_bcd(occ_m)));
        @(posedge clk); #1 entry_req = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset while the exit gate is open.
        @(posedge clk); #1 exit_req = 1'b1;
        wait_hi(1, 12, "rst_exit_open_timeout");
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_gate", 32'(gate_out_open), 0);
        check_val("async_rst_bcd", 32'(bcd_out), 32'h0003);
        occ_m = 0;
        exit_req = 1'b0;
        check_val("scoreboard_drained", sb.size(), 0);
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
        check_val("post_rst_bcd", 32'(bcd_out), 32'(model_bcd(occ_m)));
        check_val("post_rst_gates", 32'({gate_in_open, gate_out_open}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_display_ctrl.md
Name: parking_display_ctrl

Overview:
- Sequences the car park's entry and exit gates and owns the occupancy and free-space counts shown on the 4-digit multiplexed 7-segment display.
- Arbitrates between the entry and exit gate requesters and drives the packed BCD word {occupied, free} to the digit multiplexer.
- Generates the multiplexer's scan tick and a blank/flash control used when the park is full.

Parameters:
- CAPACITY, 8'd20: number of spaces; legal range 1..99; held as a constant.
- GATE_CYCLES, 16'd50000: clock cycles a gate stays open waiting for the car-passed sensor.
- SCAN_DIV, 16'd1000: period, in clocks, of the scan_tick pulse; must be >= 2.
- FLASH_DIV, 24'd500000: half-period, in clocks, of the full-indicator flash.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- entry_req, input, 1: level; car waiting at the entry gate.
- exit_req, input, 1: level; car waiting at the exit gate.
- entry_done, input, 1: one-cycle pulse; car has cleared the entry gate.
- exit_done, input, 1: one-cycle pulse; car has cleared the exit gate.
- gate_in_open, output, 1: entry barrier open.
- gate_out_open, output, 1: exit barrier open.
- entry_ack, output, 1: one-cycle pulse; entry counted.
- exit_ack, output, 1: one-cycle pulse; exit counted.
- entry_deny, output, 1: level; entry refused because the park is full.
- full, output, 1: occupied == CAPACITY.
- bcd_out, output, 16: [15:12],[11:8] = occupied tens/units; [7:4],[3:0] = free tens/units.
- scan_tick, output, 1: one-cycle pulse that advances the digit multiplexer.
- blank, output, 1: display blank request.

Behaviour:
- Reset (asynchronous, active-high; also mid-operation): state IDLE, occupied = 00, free = CAPACITY in BCD, both gates closed, all pulse outputs 0, entry_deny = 0, full = 0, blank = 0, all counters 0. A reset during an open gate closes the gate and discards the transaction.
- All outputs are registered. bcd_out reflects a count update on the cycle after the corresponding ack pulse.
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, RELEASE.
- IDLE:
  - If exit_req = 1 and occupied != 0, go to EXIT_OPEN. Exit has priority on simultaneous requests because it frees space.
  - Else if entry_req = 1 and full = 0, go to ENTRY_OPEN.
  - exit_req with occupied = 00 is ignored.
- entry_deny = 1 while the FSM is in IDLE, entry_req = 1, full = 1 and no exit is being granted. entry_deny = 0 otherwise.
- ENTRY_OPEN (EXIT_OPEN is symmetric):
  - gate_in_open = 1 and the gate timer counts from 0.
  - On entry_done: occupied +1, free -1 (BCD), entry_ack pulse, go to RELEASE.
  - On timer = GATE_CYCLES-1 without entry_done: timeout, no count change, no ack, go to RELEASE.
  - The *_done input for the gate that is not open is ignored.
- RELEASE: gates closed. Stay until the request line for the gate just served is 0, then go to IDLE. This prevents double counting one car.
- BCD arithmetic (bcd2_incdec):
  - Units digit 9 +1 gives 0 with a carry to tens.
  - Units digit 0 -1 gives 9 with a borrow from tens.
  - Counts never go below 00 or above CAPACITY. The guards above make these cases unreachable; saturation is still required.
- full updates in the same cycle as the count register.
- scan_tick: free-running divider; pulses on divider = SCAN_DIV-1, then the divider wraps to 0. Independent of the FSM.
- blank:
  - When full = 1, toggles every FLASH_DIV clocks.
  - When full = 0, blank = 0 and the flash counter clears.

Decomposition:
- Shared package parking_pkg holds:
  - the FSM state encoding (2-bit localparams),
  - the BCD digit width (4),
  - the bcd_out field offsets.
- Sub-module bcd2_incdec: 2-digit BCD increment/decrement with saturation. Instantiated twice, for occupied and free.

Test Plan (CAPACITY=3, GATE_CYCLES=8, SCAN_DIV=4, FLASH_DIV=6):
- Reset released, no stimulus -> bcd_out = 16'h0003, gates closed, scan_tick pulses every 4 cycles.
- entry_req = 1, entry_done pulse 3 cycles after gate_in_open, then entry_req dropped -> entry_ack pulse, bcd_out = 16'h0102, FSM returns to IDLE.
- Three entries, then entry_req held -> full = 1, entry_deny = 1, gate_in_open stays 0, blank toggles every 6 cycles.
- entry_req and exit_req asserted in the same cycle with occupied = 2 -> gate_out_open first; after exit_done, bcd_out = 16'h0102; entry is then served.
- Entry gate open with no entry_done -> gate closes after 8 cycles, no ack, bcd_out unchanged. Holding entry_req does not reopen the gate until it is dropped.
- reset asserted while gate_out_open = 1 -> gate closes asynchronously, bcd_out = 16'h0003.
